// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory dump block.
// Holds the halfword index map of data memory and the dump FSM states.
// Optional feature macro: DMEM_DUMP_CHECKSUM_EN (adds the CSUM state).
package dmem_pkg;

    // Halfword index width: mem_a carries the index in bits [8:1].
    localparam int HW_IDX_W     = 8;

    // Data memory regions, as halfword index ranges.
    localparam int ROM_FIRST    = 0;
    localparam int ROM_LAST     = 15;
    localparam int RAM_FIRST    = 16;
    localparam int RAM_LAST     = 47;
    localparam int VERIFY_FIRST = 48;
    localparam int VERIFY_LAST  = 63;

    // Dump sequencer states; CSUM exists only when the checksum word is built.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
`ifdef DMEM_DUMP_CHECKSUM_EN
        CSUM = 3'd3,
`endif
        DONE = 3'd4
    } dump_state_t;

endpackage

// File: rtl/dmem_dump.sv
// dmem_dump -- streams COUNT halfwords of data memory, starting at BASE_IDX,
// out over a valid/ready interface; one word per two cycles at full rate.
// Optional feature macro: DMEM_DUMP_CHECKSUM_EN appends a 16-bit wrapping
// sum of the dumped words as a final stream word.
module dmem_dump
    import dmem_pkg::*;
#(
    parameter int BASE_IDX = VERIFY_FIRST,
    parameter int COUNT    = VERIFY_LAST - VERIFY_FIRST + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_a,
    input  logic [31:0] mem_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last
);

    localparam logic [HW_IDX_W-1:0] FIRST_IDX = HW_IDX_W'(BASE_IDX);
    localparam logic [HW_IDX_W-1:0] LAST_IDX  = HW_IDX_W'(BASE_IDX + COUNT - 1);

    dump_state_t         state;
    dump_state_t         state_nxt;
    logic [HW_IDX_W-1:0] idx;
    logic                handshake;
    logic                last_word;
    logic                unused_rd_hi;

    assign handshake    = out_valid && out_ready;
    assign last_word    = (idx == LAST_IDX);
    // Only the low halfword of the read port carries data.
    assign unused_rd_hi = ^mem_rd[31:16];

`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [15:0] sum;
    logic [15:0] sum_next;

    assign sum_next = sum + out_data;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the state-decoded outputs busy, done and mem_a.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        mem_a     = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                mem_a     = {23'd0, idx, 1'b0};
                state_nxt = SEND;
            end
            SEND: begin
                if (handshake) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                    state_nxt = last_word ? CSUM : LOAD;
`else
                    state_nxt = last_word ? DONE : LOAD;
`endif
                end
            end
`ifdef DMEM_DUMP_CHECKSUM_EN
            CSUM: begin
                if (handshake) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: index walk, output word register and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= FIRST_IDX;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx <= FIRST_IDX;
`ifdef DMEM_DUMP_CHECKSUM_EN
                        sum <= '0;
`endif
                    end
                end
                LOAD: begin
                    out_data  <= mem_rd[15:0];
                    out_valid <= 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= last_word;
`endif
                end
                SEND: begin
                    if (handshake) begin
                        if (!last_word) begin
                            idx <= idx + 1'b1;
                        end
`ifdef DMEM_DUMP_CHECKSUM_EN
                        sum <= sum_next;
                        if (last_word) begin
                            // Checksum word follows the last data word directly.
                            out_data  <= sum_next;
                            out_valid <= 1'b1;
                            out_last  <= 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end
`else
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
`endif
                    end
                end
`ifdef DMEM_DUMP_CHECKSUM_EN
                CSUM: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
